sys_bridge: RTL and testbench

- Parametrised multi-cycle system bridge between the CPU data port and N memory-mapped slots: data memory, timers and future peripherals.
- Decodes addresses by base/mask, drives one slot per transaction and waits for that slot's ready handshake.
- Returns registered read data with an ack pulse.
- Flags unmapped addresses and slot timeouts as bus errors and latches the faulting address for exception handling.

---
 rtl/sys_bridge_pkg.sv | 26 ++
 rtl/sys_bridge_addr_decoder.sv | 30 +++
 rtl/sys_bridge.sv | 133 +++++++++++++
 tb/tb_sys_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bridge_pkg.sv
// Shared types and constants for the CPU-to-slot system bridge.
// Slot map defaults: data memory, timer 0, timer 1.
package sys_bridge_pkg;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   localparam logic [AW-1:0] DM_BASE  = 32'h0000_0000;
   localparam logic [AW-1:0] DM_MASK  = 32'hFFFF_C000;
   localparam logic [AW-1:0] TC0_BASE = 32'h0000_7F00;
   localparam logic [AW-1:0] TC0_MASK = 32'hFFFF_FFF0;
   localparam logic [AW-1:0] TC1_BASE = 32'h0000_7F10;
   localparam logic [AW-1:0] TC1_MASK = 32'hFFFF_FFF0;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sys_bridge_addr_decoder.sv
// Parallel base/mask slot decoder; the lowest hitting slot wins.
module addr_decoder
   import sys_bridge_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [AW-1:0]   addr_i,
   input  logic [N*AW-1:0] base_i,
   input  logic [N*AW-1:0] mask_i,
   output logic            hit_o,
   output logic [IW-1:0]   idx_o,
   output logic [N-1:0]    onehot_o
);

   // Walk high to low so the lowest index overrides on overlap.
   always_comb begin
      hit_o    = 1'b0;
      idx_o    = '0;
      onehot_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if ((addr_i & mask_i[i*AW +: AW]) == base_i[i*AW +: AW]) begin
            hit_o    = 1'b1;
            idx_o    = IW'(i);
            onehot_o = N'(1) << i;
         end
      end
   end

endmodule

// File: rtl/sys_bridge.sv
// Multi-cycle bridge from the CPU data port to N memory-mapped slots,
// with bus-error reporting for unmapped addresses and slot timeouts.
module sys_bridge
   import sys_bridge_pkg::*;
#(
   parameter int                    N_SLV    = 3,
   parameter logic [N_SLV*AW-1:0]   SLV_BASE = {TC1_BASE, TC0_BASE, DM_BASE},
   parameter logic [N_SLV*AW-1:0]   SLV_MASK = {TC1_MASK, TC0_MASK, DM_MASK},
   parameter int                    TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cpu_req,
   input  logic [AW-1:0]       cpu_addr,
   input  logic [DW-1:0]       cpu_wdata,
   input  logic [BW-1:0]       cpu_byteen,
   output logic                cpu_busy,
   output logic                cpu_ack,
   output logic [DW-1:0]       cpu_rdata,
   output logic                cpu_err,
   output logic [AW-1:0]       cpu_err_addr,
   output logic [N_SLV-1:0]    slv_sel,
   output logic [AW-1:0]       slv_addr,
   output logic [DW-1:0]       slv_wdata,
   output logic [BW-1:0]       slv_byteen,
   input  logic [N_SLV-1:0]    slv_ready,
   input  logic [N_SLV*DW-1:0] slv_rdata
);

   localparam int IW = idx_w(N_SLV);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_e             state_q;
   logic [IW-1:0]      idx_q;
   logic [N_SLV-1:0]   sel_q;
   logic [AW-1:0]      addr_q;
   logic [DW-1:0]      wdata_q;
   logic [BW-1:0]      be_q;
   logic [CW-1:0]      cnt_q;
   logic [DW-1:0]      rdata_q;
   logic               err_q;
   logic [AW-1:0]      err_addr_q;

   logic               dec_hit;
   logic [IW-1:0]      dec_idx;
   logic [N_SLV-1:0]   dec_oh;
   logic               in_acc;
   logic               tmo;

   addr_decoder #(
      .N  (N_SLV),
      .IW (IW)
   ) u_dec (
      .addr_i   (cpu_addr),
      .base_i   (SLV_BASE),
      .mask_i   (SLV_MASK),
      .hit_o    (dec_hit),
      .idx_o    (dec_idx),
      .onehot_o (dec_oh)
   );

   assign in_acc = (state_q == S_ACCESS);
   assign tmo    = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         sel_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cpu_req) begin
                  addr_q  <= cpu_addr;
                  wdata_q <= cpu_wdata;
                  be_q    <= cpu_byteen;
                  cnt_q   <= '0;
                  if (dec_hit) begin
                     idx_q   <= dec_idx;
                     sel_q   <= dec_oh;
                     state_q <= S_ACCESS;
                  end else begin
                     err_q      <= 1'b1;
                     rdata_q    <= '0;
                     err_addr_q <= cpu_addr;
                     state_q    <= S_RESP;
                  end
               end
            end
            S_ACCESS: begin
               // Ready beats a coincident timeout.
               if (slv_ready[idx_q]) begin
                  rdata_q <= (be_q == '0) ? slv_rdata[idx_q*DW +: DW] : '0;
                  err_q   <= 1'b0;
                  sel_q   <= '0;
                  state_q <= S_RESP;
               end else if (tmo) begin
                  rdata_q    <= '0;
                  err_q      <= 1'b1;
                  err_addr_q <= addr_q;
                  sel_q      <= '0;
                  state_q    <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RESP: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_busy     = (state_q != S_IDLE);
   assign cpu_ack      = (state_q == S_RESP);
   assign cpu_rdata    = rdata_q;
   assign cpu_err      = err_q;
   assign cpu_err_addr = err_addr_q;
   assign slv_sel      = sel_q;
   assign slv_addr     = in_acc ? addr_q : '0;
   assign slv_wdata    = in_acc ? wdata_q : '0;
   assign slv_byteen   = in_acc ? be_q : '0;

endmodule

// File: tb/tb_sys_bridge.sv
// Scoreboard bench for sys_bridge: default slot map plus an overlapping
// map instance for priority checks.
module tb_sys_bridge;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] eaddr;
   } exp_t;

   exp_t sb[$];

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req, req2;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0]  cpu_byteen;
   logic        cpu_busy, cpu_ack, cpu_err;
   logic [31:0] cpu_rdata, cpu_err_addr;
   logic [2:0]  slv_sel, slv_ready;
   logic [31:0] slv_addr, slv_wdata;
   logic [3:0]  slv_byteen;
   logic [95:0] slv_rdata;

   logic        busy2, ack2, err2;
   logic [31:0] rdata2, eaddr2, saddr2, swd2;
   logic [2:0]  sel2;
   logic [3:0]  sbe2;

   int errs = 0;
   int checks = 0;
   int rdy_delay = 0;
   int acc_n = 0;
   int ack_cnt = 0;
   logic [2:0]  stray = 3'b000;
   logic [31:0] last_err = 32'h0;

   always #5 clk = ~clk;

   assign slv_rdata = {32'hA5A5_0002, 32'hCAFE_0001, 32'hDEAD_BEEF};
   assign slv_ready = ((rdy_delay != 0 && slv_sel != 3'b0
                        && acc_n == rdy_delay - 1) ? slv_sel : 3'b0)
                      | stray;

   always @(posedge clk) begin
      acc_n <= (slv_sel == 3'b0) ? 0 : acc_n + 1;
      if (cpu_ack) ack_cnt <= ack_cnt + 1;
   end

   sys_bridge u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cpu_req      (cpu_req),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_byteen   (cpu_byteen),
      .cpu_busy     (cpu_busy),
      .cpu_ack      (cpu_ack),
      .cpu_rdata    (cpu_rdata),
      .cpu_err      (cpu_err),
      .cpu_err_addr (cpu_err_addr),
      .slv_sel      (slv_sel),
      .slv_addr     (slv_addr),
      .slv_wdata    (slv_wdata),
      .slv_byteen   (slv_byteen),
      .slv_ready    (slv_ready),
      .slv_rdata    (slv_rdata)
   );

   sys_bridge #(
      .SLV_BASE ({32'h0000_7F10, 32'h0000_7F00, 32'h0000_4000})
   ) u_ovl (
      .clk          (clk),
      .reset_n      (reset_n),
      .cpu_req      (req2),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_byteen   (cpu_byteen),
      .cpu_busy     (busy2),
      .cpu_ack      (ack2),
      .cpu_rdata    (rdata2),
      .cpu_err      (err2),
      .cpu_err_addr (eaddr2),
      .slv_sel      (sel2),
      .slv_addr     (saddr2),
      .slv_wdata    (swd2),
      .slv_byteen   (sbe2),
      .slv_ready    (sel2),
      .slv_rdata    (slv_rdata)
   );

   task automatic txn(
      input  logic [31:0] a,
      input  logic [31:0] w,
      input  logic [3:0]  be,
      input  bit          hold,
      output int          lat,
      output int          selc,
      output logic [2:0]  sel_seen,
      output logic [3:0]  be_seen,
      output logic [31:0] wd_seen,
      output bit          stable
   );
      @(negedge clk);
      cpu_addr = a; cpu_wdata = w; cpu_byteen = be; cpu_req = 1'b1;
      lat = 0; selc = 0; sel_seen = '0; be_seen = '0; wd_seen = '0;
      stable = 1'b1;
      while (lat < 64) begin
         @(negedge clk);
         lat++;
         if (hold) begin
            cpu_addr = ~a; cpu_wdata = ~w;
         end else begin
            cpu_req = 1'b0;
         end
         if (cpu_ack) break;
         if (slv_sel != 3'b0) begin
            if (slv_addr !== a) stable = 1'b0;
            if (selc > 0 && (slv_sel !== sel_seen || slv_byteen !== be_seen
                             || slv_wdata !== wd_seen))
               stable = 1'b0;
            selc++;
            sel_seen = slv_sel; be_seen = slv_byteen; wd_seen = slv_wdata;
         end
      end
      cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      cpu_req = 0; req2 = 0; cpu_addr = 0; cpu_wdata = 0; cpu_byteen = 0;
      #3 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cpu_busy, cpu_ack, cpu_err, cpu_rdata, cpu_err_addr, slv_sel,
           slv_addr, slv_wdata, slv_byteen} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: busy=%b ack=%b sel=%b rdata=%h eaddr=%h want all 0",
                  cpu_busy, cpu_ack, slv_sel, cpu_rdata, cpu_err_addr);
      end
      reset_n = 1'b1;
   endtask

   task automatic check_resp(input string nm);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errs++;
         $display("FAIL %s_sb: scoreboard empty", nm);
         return;
      end
      e = sb.pop_front();
      if (cpu_ack !== 1'b1 || cpu_rdata !== e.rdata || cpu_err !== e.err
          || cpu_err_addr !== e.eaddr) begin
         errs++;
         $display("FAIL %s_resp: ack=%b rdata=%h err=%b eaddr=%h want ack=1 rdata=%h err=%b eaddr=%h",
                  nm, cpu_ack, cpu_rdata, cpu_err, cpu_err_addr,
                  e.rdata, e.err, e.eaddr);
      end
   endtask

   task automatic test_read();
      int lat, selc; logic [2:0] s; logic [3:0] b; logic [31:0] w; bit st;
      rdy_delay = 1;
      sb.push_back('{32'hDEAD_BEEF, 1'b0, last_err});
      txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, lat, selc, s, b, w, st);
      checks++;
      if (lat !== 2 || selc !== 1 || s !== 3'b001) begin
         errs++;
         $display("FAIL read_timing: lat=%0d selc=%0d sel=%b want 2 1 001", lat, selc, s);
      end
      check_resp("read");
   endtask

   task automatic test_write();
      int lat, selc; logic [2:0] s; logic [3:0] b; logic [31:0] w; bit st;
      rdy_delay = 3;
      stray = 3'b101;
      sb.push_back('{32'h0, 1'b0, last_err});
      txn(32'h0000_7F04, 32'h1234, 4'hF, 1'b0, lat, selc, s, b, w, st);
      stray = 3'b000;
      checks++;
      if (lat !== 4 || selc !== 3 || s !== 3'b010 || !st) begin
         errs++;
         $display("FAIL write_timing: lat=%0d selc=%0d sel=%b stable=%b want 4 3 010 1",
                  lat, selc, s, st);
      end
      checks++;
      if (b !== 4'hF || w !== 32'h1234) begin
         errs++;
         $display("FAIL write_bus: byteen=%h wdata=%h want f 00001234", b, w);
      end
      check_resp("write");
   endtask

   task automatic test_unmapped();
      int lat, selc; logic [2:0] s; logic [3:0] b; logic [31:0] w; bit st;
      rdy_delay = 1;
      last_err = 32'h0000_8000;
      sb.push_back('{32'h0, 1'b1, last_err});
      txn(32'h0000_8000, 32'h0, 4'h0, 1'b0, lat, selc, s, b, w, st);
      checks++;
      if (lat !== 1 || selc !== 0) begin
         errs++;
         $display("FAIL unmapped_timing: lat=%0d selc=%0d want 1 0", lat, selc);
      end
      check_resp("unmapped");
   endtask

   task automatic test_timeout();
      int lat, selc; logic [2:0] s; logic [3:0] b; logic [31:0] w; bit st;
      rdy_delay = 0;
      last_err = 32'h0000_7F14;
      sb.push_back('{32'h0, 1'b1, last_err});
      txn(32'h0000_7F14, 32'h0, 4'h0, 1'b0, lat, selc, s, b, w, st);
      checks++;
      if (lat !== 17 || selc !== 16 || s !== 3'b100 || !st) begin
         errs++;
         $display("FAIL timeout_timing: lat=%0d selc=%0d sel=%b want 17 16 100", lat, selc, s);
      end
      check_resp("timeout");
      rdy_delay = 16;
      sb.push_back('{32'hA5A5_0002, 1'b0, last_err});
      txn(32'h0000_7F14, 32'h0, 4'h0, 1'b0, lat, selc, s, b, w, st);
      checks++;
      if (lat !== 17 || selc !== 16) begin
         errs++;
         $display("FAIL tmo_ready_timing: lat=%0d selc=%0d want 17 16", lat, selc);
      end
      check_resp("tmo_ready");
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 32'hA5A5_0002 || cpu_err !== 1'b0) begin
         errs++;
         $display("FAIL hold_after_ack: ack=%b rdata=%h err=%b want 0 a5a50002 0",
                  cpu_ack, cpu_rdata, cpu_err);
      end
   endtask

   task automatic test_busy_req();
      int lat, selc, a0; logic [2:0] s; logic [3:0] b; logic [31:0] w; bit st;
      rdy_delay = 3;
      a0 = ack_cnt;
      sb.push_back('{32'hCAFE_0001, 1'b0, last_err});
      txn(32'h0000_7F04, 32'h55, 4'h0, 1'b1, lat, selc, s, b, w, st);
      checks++;
      if (lat !== 4 || selc !== 3 || s !== 3'b010 || !st) begin
         errs++;
         $display("FAIL busy_timing: lat=%0d selc=%0d sel=%b stable=%b want 4 3 010 1",
                  lat, selc, s, st);
      end
      check_resp("busy");
      repeat (6) @(negedge clk);
      checks++;
      if (ack_cnt !== a0 + 1 || cpu_busy !== 1'b0) begin
         errs++;
         $display("FAIL busy_single_ack: acks=%0d busy=%b want %0d 0",
                  ack_cnt - a0, cpu_busy, 1);
      end
   endtask

   task automatic test_overlap();
      int n;
      @(negedge clk);
      cpu_addr = 32'h0000_7F00; cpu_byteen = 4'h0; req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      checks++;
      if (sel2 !== 3'b001) begin
         errs++;
         $display("FAIL overlap_sel: sel=%b want 001", sel2);
      end
      n = 0;
      while (!ack2 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ack2 !== 1'b1 || rdata2 !== 32'hDEAD_BEEF || err2 !== 1'b0) begin
         errs++;
         $display("FAIL overlap_resp: ack=%b rdata=%h err=%b want 1 deadbeef 0",
                  ack2, rdata2, err2);
      end
   endtask

   task automatic test_reset_mid();
      int a0, lat, selc; logic [2:0] s; logic [3:0] b; logic [31:0] w; bit st;
      rdy_delay = 0;
      @(negedge clk);
      cpu_addr = 32'h0000_7F14; cpu_wdata = 32'h77; cpu_byteen = 4'h3;
      cpu_req = 1'b1;
      @(negedge clk);
      cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (slv_sel !== 3'b100) begin
         errs++;
         $display("FAIL rst_pre_sel: sel=%b want 100", slv_sel);
      end
      a0 = ack_cnt;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({cpu_busy, cpu_ack, cpu_err, cpu_rdata, cpu_err_addr, slv_sel,
           slv_addr, slv_wdata, slv_byteen} !== '0) begin
         errs++;
         $display("FAIL rst_async: busy=%b sel=%b saddr=%h rdata=%h eaddr=%h want all 0",
                  cpu_busy, slv_sel, slv_addr, cpu_rdata, cpu_err_addr);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ack_cnt !== a0 || cpu_busy !== 1'b0) begin
         errs++;
         $display("FAIL rst_no_ack: acks=%0d busy=%b want 0 0", ack_cnt - a0, cpu_busy);
      end
      last_err = 32'h0;
      rdy_delay = 1;
      sb.push_back('{32'hDEAD_BEEF, 1'b0, last_err});
      txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, lat, selc, s, b, w, st);
      checks++;
      if (lat !== 2 || s !== 3'b001) begin
         errs++;
         $display("FAIL post_rst_timing: lat=%0d sel=%b want 2 001", lat, s);
      end
      check_resp("post_rst");
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_unmapped();
      test_timeout();
      test_busy_req();
      test_overlap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
